alu_driver: RTL and testbench

Program sequencer and result collector for the 4-bit accumulator ALU (`Top_alu`). The host loads a short program of {Inst, A} words into an on-chip FIFO. On `start`, the block clears the ALU accumulator, issues the words one at a time and returns each post-operation accumulator value through a valid/ready result port. It is the initiating end of the ALU's Inst/A/OUT interface and sits between the host bus and the ALU.

---
 rtl/alu_driver.sv | 135 +++++++++++++
 tb/tb_alu_driver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_driver.sv
// Program sequencer for the 4-bit accumulator ALU: buffers {inst, a} words in a FIFO,
// replays them on start and returns each post-op accumulator value over valid/ready.
module alu_driver #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          prog_valid,
  output logic          prog_ready,
  input  logic [1:0]    prog_inst,
  input  logic [3:0]    prog_a,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          alu_reset,
  output logic [1:0]    alu_inst,
  output logic [3:0]    alu_a,
  input  logic [3:0]    alu_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [3:0]    res_data,
  output logic [AW-1:0] res_idx
);

  typedef enum logic [2:0] {StIdle, StClear, StIssue, StCapture, StResp} state_e;

  localparam logic [AW:0]   CntDepth = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CntOne   = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne   = AW'(1);

  state_e        state_q, state_d;
  logic [5:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, idx_q;
  logic [AW:0]   count_q;
  logic          done_q, done_d;
  logic          res_valid_q;
  logic [3:0]    res_data_q;
  logic [AW-1:0] res_idx_q;
  logic          push, pop, capture, handshake;

  assign prog_ready = (state_q == StIdle) && (count_q < CntDepth);
  assign push       = prog_valid && prog_ready;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign alu_reset  = RESET || (state_q == StClear);
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_idx    = res_idx_q;

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    // NOP (add 0) keeps the free-running accumulator unchanged.
    alu_inst  = 2'b00;
    alu_a     = 4'b0000;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StClear;
      end
      StClear: begin
        if (count_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        pop      = 1'b1;
        alu_inst = mem_q[rd_ptr_q][5:4];
        alu_a    = mem_q[rd_ptr_q][3:0];
        state_d  = StCapture;
      end
      StCapture: begin
        capture = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        if (res_valid_q && res_ready) begin
          handshake = 1'b1;
          if (count_q != '0) begin
            state_d = StIssue;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
        count_q  <= count_q + CntOne;
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
        count_q  <= count_q - CntOne;
      end
      if (state_q == StClear) idx_q <= '0;
      else if (handshake) idx_q <= idx_q + PtrOne;
      if (capture) begin
        res_valid_q <= 1'b1;
        res_data_q  <= alu_out;
        res_idx_q   <= idx_q;
      end else if (handshake) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {prog_inst, prog_a};
  end

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a behavioural 4-bit accumulator ALU attached.
module tb_alu_driver;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       prog_valid = 1'b0;
  logic       prog_ready;
  logic [1:0] prog_inst = 2'b00;
  logic [3:0] prog_a = 4'b0000;
  logic       start = 1'b0;
  logic       busy, done, alu_reset;
  logic [1:0] alu_inst;
  logic [3:0] alu_a, alu_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic [2:0] res_idx;
  logic [3:0] acc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_driver #(.DEPTH(8), .AW(3)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_inst  (prog_inst),
    .prog_a     (prog_a),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .alu_reset  (alu_reset),
    .alu_inst   (alu_inst),
    .alu_a      (alu_a),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_idx    (res_idx)
  );

  // Accumulator ALU: executes every clock, registered output.
  always_ff @(posedge clk) begin
    if (alu_reset) acc <= 4'd0;
    else begin
      case (alu_inst)
        2'b00:   acc <= acc + alu_a;
        2'b01:   acc <= acc - alu_a;
        2'b10:   acc <= acc * alu_a;
        default: acc <= ~(acc ^ alu_a);
      endcase
    end
  end
  assign alu_out = acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] i, input logic [3:0] a, input logic exp_rdy);
    @(negedge clk);
    prog_valid = 1'b1;
    prog_inst  = i;
    prog_a     = a;
    chk("prog_ready", 32'(prog_ready), 32'(exp_rdy));
    @(negedge clk);
    prog_valid = 1'b0;
  endtask

  // Ends in the cycle after start was sampled (CLEAR).
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic get_result(input logic [3:0] ed, input int ei, input int ewait, input int hold);
    int n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("res_wait", 32'(n), 32'(ewait));
    chk("res_data", 32'(res_data), 32'(ed));
    chk("res_idx", 32'(res_idx), 32'(ei));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(res_valid), 32'(1));
      chk("hold_data", 32'(res_data), 32'(ed));
      chk("hold_idx", 32'(res_idx), 32'(ei));
      chk("hold_nop", 32'({alu_inst, alu_a}), 32'(0));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_clr", 32'(res_valid), 32'(0));
  endtask

  task automatic chk_done();
    chk("done_pulse", 32'(done), 32'(1));
    chk("busy_end", 32'(busy), 32'(0));
    @(negedge clk);
    chk("done_once", 32'(done), 32'(0));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_alu_reset", 32'(alu_reset), 32'(1));
    chk("rst_prog_ready", 32'(prog_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_res", 32'({res_valid, res_data, res_idx}), 32'(0));
    chk("rst_alu_bus", 32'({alu_inst, alu_a}), 32'(0));
    RESET = 1'b0;
    @(negedge clk);
    chk("alu_reset_off", 32'(alu_reset), 32'(0));

    // Basic program: 3, 8, 6, 15
    push(2'b00, 4'd3, 1'b1);
    push(2'b00, 4'd5, 1'b1);
    push(2'b01, 4'd2, 1'b1);
    push(2'b11, 4'd6, 1'b1);
    kick();
    chk("clear_alu_reset", 32'(alu_reset), 32'(1));
    chk("clear_busy", 32'(busy), 32'(1));
    chk("clear_no_write", 32'(prog_ready), 32'(0));
    @(negedge clk);
    chk("issue_bus", 32'({alu_inst, alu_a}), 32'({2'b00, 4'd3}));
    get_result(4'd3, 0, 2, 0);
    get_result(4'd8, 1, 2, 0);
    get_result(4'd6, 2, 2, 0);
    get_result(4'd15, 3, 2, 0);
    chk_done();

    // Wrap-around, second word written in the same cycle as start
    push(2'b00, 4'd9, 1'b1);
    @(negedge clk);
    prog_valid = 1'b1;
    prog_inst  = 2'b00;
    prog_a     = 4'd9;
    start      = 1'b1;
    @(negedge clk);
    prog_valid = 1'b0;
    start      = 1'b0;
    get_result(4'd9, 0, 3, 0);
    get_result(4'd2, 1, 2, 0);
    chk_done();

    // Backpressure: 5, 4, 6
    push(2'b00, 4'd5, 1'b1);
    push(2'b01, 4'd1, 1'b1);
    push(2'b00, 4'd2, 1'b1);
    kick();
    get_result(4'd5, 0, 3, 5);
    get_result(4'd4, 1, 2, 3);
    get_result(4'd6, 2, 2, 0);
    chk_done();

    // Full FIFO with pointers starting mid-array; 9th word dropped
    for (int i = 0; i < 8; i++) push(2'b00, 4'd1, 1'b1);
    push(2'b00, 4'd8, 1'b0);
    kick();
    for (int i = 0; i < 8; i++) get_result(4'(i + 1), i, (i == 0) ? 3 : 2, 0);
    chk_done();
    push(2'b00, 4'd2, 1'b1);
    push(2'b01, 4'd1, 1'b1);
    kick();
    get_result(4'd2, 0, 3, 0);
    get_result(4'd1, 1, 2, 0);
    chk_done();

    // Empty start, with res_ready high while res_valid is low
    res_ready = 1'b1;
    kick();
    chk("empty_alu_reset", 32'(alu_reset), 32'(1));
    @(negedge clk);
    chk("empty_res_valid", 32'(res_valid), 32'(0));
    chk("empty_alu_reset_off", 32'(alu_reset), 32'(0));
    chk_done();
    res_ready = 1'b0;

    // RESET during CAPTURE of op 0, then a fresh program from accumulator 0
    push(2'b00, 4'd3, 1'b1);
    push(2'b00, 4'd4, 1'b1);
    push(2'b00, 4'd5, 1'b1);
    push(2'b00, 4'd6, 1'b1);
    kick();
    repeat (2) @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'(1));
    RESET = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_res_valid", 32'(res_valid), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_alu_reset", 32'(alu_reset), 32'(1));
    RESET = 1'b0;
    @(negedge clk);
    chk("abort_done_after", 32'(done), 32'(0));
    chk("abort_ready", 32'(prog_ready), 32'(1));
    push(2'b00, 4'd7, 1'b1);
    push(2'b01, 4'd2, 1'b1);
    kick();
    get_result(4'd7, 0, 3, 0);
    get_result(4'd5, 1, 2, 0);
    chk_done();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
